// File: rtl/fcpu_pkg.sv
`default_nettype none
// ============================================================================
// fcpu_pkg : shared FSM state types and AXI response codes for fcpu io path
// Rev 1.0
// ============================================================================
package fcpu_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/fcpu_byte_fifo.sv
`default_nettype none
// ============================================================================
// fcpu_byte_fifo : show-ahead byte FIFO, DEPTH entries (power of two, >= 2)
// Rev 1.0
// ============================================================================
module fcpu_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [c_PTR_W:0] r_wr_ptr;
    logic [c_PTR_W:0] r_rd_ptr;
    logic [7:0]       r_mem [DEPTH];
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fcpu_io_axi_responder.sv
`default_nettype none
// ============================================================================
// fcpu_io_axi_responder : AXI4 byte responder bridging fcpu io_* to serial TX/RX
// Rev 1.0
// ============================================================================
module fcpu_io_axi_responder
    import fcpu_pkg::*;
#(
    parameter int                ID_W        = 4,
    parameter int                ADDR_W      = 32,
    parameter int                RX_DEPTH    = 16,
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(32'h0000_0004)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [7:0]        s_awlen,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [7:0]        s_wdata,
    input  logic              s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [ID_W-1:0]   s_rid,
    output logic [7:0]        s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    // ---------------- write path ----------------
    w_state_e        r_wstate;
    w_state_e        w_wstate_nxt;
    logic [ID_W-1:0] r_awid;
    logic [7:0]      r_awlen;
    logic [7:0]      r_wcnt;
    logic            r_werr;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid;
    logic            w_awready;
    logic            w_wready;
    logic            w_bvalid;
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_wlast_exp;

    assign w_wlast_exp = (r_wcnt == r_awlen);
    assign s_awready   = w_awready && !rst;
    assign s_wready    = w_wready;
    assign s_bvalid    = w_bvalid;
    assign s_bid       = r_awid;
    assign s_bresp     = r_werr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign w_aw_hs     = s_awvalid && s_awready;
    assign w_w_hs      = s_wvalid && s_wready;
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wstate <= W_IDLE;
        else     r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        w_bvalid     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                w_awready = 1'b1;
                if (s_awvalid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                w_wready = !r_tx_valid || tx_ready;
                if (s_wvalid && w_wready && w_wlast_exp) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                w_bvalid = 1'b1;
                if (s_bready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // A new load wins over a drain, so back-to-back beats stream at one byte per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awid     <= '0;
            r_awlen    <= '0;
            r_wcnt     <= '0;
            r_werr     <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_awid  <= s_awid;
                r_awlen <= s_awlen;
                r_wcnt  <= '0;
                r_werr  <= 1'b0;
            end else if (w_w_hs) begin
                if (s_wlast != w_wlast_exp) r_werr <= 1'b1;
                if (!w_wlast_exp)           r_wcnt <= r_wcnt + 8'd1;
            end
            if (w_w_hs && s_wstrb) begin
                r_tx_data  <= s_wdata;
                r_tx_valid <= 1'b1;
            end else if (tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    r_state_e        r_rstate;
    r_state_e        w_rstate_nxt;
    logic [ID_W-1:0] r_arid;
    logic [7:0]      r_arlen;
    logic [7:0]      r_rcnt;
    logic            r_is_stat;
    logic            w_arready;
    logic            w_rvalid;
    logic            w_ar_hs;
    logic            w_r_hs;
    logic            w_rlast;
    logic            w_pop;
    logic [7:0]      w_fifo_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;

    assign w_rlast   = (r_rstate == R_DATA) && (r_rcnt == r_arlen);
    assign s_arready = w_arready && !rst;
    assign s_rvalid  = w_rvalid;
    assign s_rlast   = w_rlast;
    assign s_rid     = r_arid;
    assign s_rresp   = AXI_RESP_OKAY;
    assign w_ar_hs   = s_arvalid && s_arready;
    assign w_r_hs    = s_rvalid && s_rready;
    assign w_pop     = w_r_hs && !r_is_stat;
    assign rx_ready  = !w_fifo_full;

    // Status byte: bit1 = RX data available, bit0 = TX slot free
    always_comb begin
        s_rdata = '0;
        if (r_rstate == R_DATA) begin
            s_rdata = r_is_stat ? {6'b0, !w_fifo_empty, !r_tx_valid} : w_fifo_head;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_arready    = 1'b0;
        w_rvalid     = 1'b0;
        if (r_rstate == R_IDLE) begin
            w_arready = 1'b1;
            if (s_arvalid) w_rstate_nxt = R_DATA;
        end else begin
            w_rvalid = r_is_stat || !w_fifo_empty;
            if (w_rvalid && s_rready && w_rlast) w_rstate_nxt = R_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arid    <= '0;
            r_arlen   <= '0;
            r_rcnt    <= '0;
            r_is_stat <= 1'b0;
        end else if (w_ar_hs) begin
            r_arid    <= s_arid;
            r_arlen   <= s_arlen;
            r_rcnt    <= '0;
            r_is_stat <= (s_araddr == STATUS_ADDR);
        end else if (w_r_hs) begin
            r_rcnt    <= r_rcnt + 8'd1;
        end
    end

    fcpu_byte_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_fcpu_io_axi_responder.sv
`default_nettype none
// ============================================================================
// tb_fcpu_io_axi_responder : directed self-checking bench for the io responder
// Rev 1.0
// ============================================================================
module tb_fcpu_io_axi_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_awid = '0;
    logic [7:0]  s_awlen = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [7:0]  s_wdata = '0;
    logic        s_wstrb = 1'b0;
    logic        s_wlast = 1'b0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [3:0]  s_bid;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [3:0]  s_arid = '0;
    logic [31:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [3:0]  s_rid;
    logic [7:0]  s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  tx_log[$];

    always #5 clk = ~clk;

    fcpu_io_axi_responder dut (
        .clk       (clk),
        .rst       (rst),
        .s_awid    (s_awid),
        .s_awlen   (s_awlen),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
    );

    // TX sink: a byte is taken on the edge following a negedge where valid&&ready
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) tx_log.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All drivers start just after a posedge and return just after a posedge
    task automatic aw_send(input logic [3:0] id, input logic [7:0] len);
        int n;
        s_awid = id; s_awlen = len; s_awvalid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_awready) break;
        end
        if (n == 200) check("aw_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [7:0] data, input logic strb, input logic last);
        int n;
        s_wdata = data; s_wstrb = strb; s_wlast = last; s_wvalid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_wready) break;
        end
        if (n == 200) check("w_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_wvalid = 1'b0; s_wlast = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int n;
        s_bready = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_bvalid) break;
        end
        if (n == 200) check({tag, "_b_timeout"}, 32'd0, 32'd1);
        check({tag, "_bid"},   32'(s_bid),   32'(id));
        check({tag, "_bresp"}, 32'(s_bresp), 32'(resp));
        @(posedge clk); #1;
        s_bready = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arvalid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_arready) break;
        end
        if (n == 200) check("ar_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic r_recv(input string tag, input logic [7:0] data, input logic last,
                          input logic [3:0] id);
        int n;
        s_rready = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_rvalid) break;
        end
        if (n == 200) check({tag, "_r_timeout"}, 32'd0, 32'd1);
        check({tag, "_rdata"}, 32'(s_rdata), 32'(data));
        check({tag, "_rlast"}, 32'(s_rlast), 32'(last));
        check({tag, "_rid"},   32'(s_rid),   32'(id));
        @(posedge clk); #1;
        s_rready = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] data);
        int n;
        rx_data = data; rx_valid = 1'b1;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rx_ready) break;
        end
        if (n == 200) check("rx_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready_gated", 32'(s_awready), 32'd0);
        check("rst_arready_gated", 32'(s_arready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_awready", 32'(s_awready), 32'd1);
        check("rst_arready", 32'(s_arready), 32'd1);
        check("rst_bvalid",  32'(s_bvalid),  32'd0);
        check("rst_rvalid",  32'(s_rvalid),  32'd0);
        check("rst_txvalid", 32'(tx_valid),  32'd0);
        check("rst_rdata",   32'(s_rdata),   32'd0);
        check("rst_rxready", 32'(rx_ready),  32'd1);
        @(posedge clk); #1;

        // 1: single-beat write
        tx_log.delete();
        aw_send(4'd3, 8'd0);
        w_send(8'h41, 1'b1, 1'b1);
        b_recv("t1", 4'd3, 2'b00);
        @(negedge clk);
        check("t1_tx_count", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() > 0) check("t1_tx_byte", 32'(tx_log[0]), 32'h41);
        @(posedge clk); #1;

        // 2: four-beat write with TX back-pressure
        tx_log.delete();
        tx_ready = 1'b0;
        aw_send(4'd1, 8'd3);
        w_send(8'h10, 1'b1, 1'b0);
        s_wdata = 8'h11; s_wstrb = 1'b1; s_wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_wready_stall", 32'(s_wready), 32'd0);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        w_send(8'h11, 1'b1, 1'b0);
        w_send(8'h12, 1'b1, 1'b0);
        w_send(8'h13, 1'b1, 1'b1);
        b_recv("t2", 4'd1, 2'b00);
        @(negedge clk);
        check("t2_tx_count", 32'(tx_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < tx_log.size()) check("t2_tx_byte", 32'(tx_log[i]), 32'h10 + 32'(i));
        end
        @(posedge clk); #1;

        // 3: wlast never asserted -> SLVERR, back to idle
        aw_send(4'd2, 8'd1);
        w_send(8'h20, 1'b1, 1'b0);
        w_send(8'h21, 1'b1, 1'b0);
        b_recv("t3", 4'd2, 2'b10);
        @(negedge clk);
        check("t3_idle_awready", 32'(s_awready), 32'd1);
        check("t3_idle_wready",  32'(s_wready),  32'd0);
        @(posedge clk); #1;

        // 4: two-beat data read
        push_rx(8'h55);
        push_rx(8'hAA);
        ar_send(4'd5, 32'h0, 8'd1);
        r_recv("t4_b0", 8'h55, 1'b0, 4'd5);
        r_recv("t4_b1", 8'hAA, 1'b1, 4'd5);
        @(negedge clk);
        check("t4_rvalid_done", 32'(s_rvalid),  32'd0);
        check("t4_arready",     32'(s_arready), 32'd1);
        @(posedge clk); #1;

        // 5: status reads
        ar_send(4'd0, 32'h4, 8'd0);
        r_recv("t5_stat_empty", 8'h01, 1'b1, 4'd0);
        push_rx(8'h77);
        ar_send(4'd0, 32'h4, 8'd0);
        r_recv("t5_stat_one", 8'h03, 1'b1, 4'd0);
        ar_send(4'd6, 32'h0, 8'd0);
        r_recv("t5_kept", 8'h77, 1'b1, 4'd6);

        // 6: fill FIFO, pop one, then reset mid-burst
        for (int i = 0; i < 16; i++) push_rx(8'h80 + 8'(i));
        @(negedge clk);
        check("t6_full_rxready", 32'(rx_ready), 32'd0);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        aw_send(4'd7, 8'd0);
        w_send(8'h99, 1'b1, 1'b1);
        ar_send(4'd2, 32'h0, 8'd3);
        r_recv("t6_b0", 8'h80, 1'b0, 4'd2);
        @(negedge clk);
        check("t6_rxready_after_pop", 32'(rx_ready), 32'd1);
        check("t6_pre_rvalid",  32'(s_rvalid), 32'd1);
        check("t6_pre_bvalid",  32'(s_bvalid), 32'd1);
        check("t6_pre_txvalid", 32'(tx_valid), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t6_rst_rvalid",  32'(s_rvalid),  32'd0);
        check("t6_rst_bvalid",  32'(s_bvalid),  32'd0);
        check("t6_rst_txvalid", 32'(tx_valid),  32'd0);
        check("t6_rst_awready", 32'(s_awready), 32'd0);
        check("t6_rst_rxready", 32'(rx_ready),  32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        ar_send(4'd0, 32'h4, 8'd0);
        r_recv("t6_stat_after_rst", 8'h01, 1'b1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
